// File: rtl/tree_plru_table_pkg.sv
// Shared constants and types for the tree pseudo-LRU replacement table.
// Optional feature macro: TREE_PLRU_INVALID_FIRST_EN (invalid-way-first victim).
package tree_plru_pkg;

    // Default geometry; modules take these as parameter defaults.
    localparam int DEF_NUM_OF_WAYS = 4;
    localparam int DEF_NUM_OF_SETS = 64;

    // Derived widths for the default geometry.
    localparam int DEF_WAY_W  = $clog2(DEF_NUM_OF_WAYS);
    localparam int DEF_SET_W  = $clog2(DEF_NUM_OF_SETS);
    localparam int DEF_TREE_W = DEF_NUM_OF_WAYS - 1;

    // One set's tree bits at the default geometry: bit (n-1) holds node n.
    typedef logic [DEF_TREE_W-1:0] tree_t;

    // INIT sweeps every set to the all-zero tree; READY serves traffic.
    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/tree_plru_table_if.sv
// Update / victim-lookup bus of the tree pseudo-LRU table.
// Optional feature macro: TREE_PLRU_INVALID_FIRST_EN adds vic_invalid_i.
interface tree_plru_table_if
    import tree_plru_pkg::*;
#(
    parameter int NUM_OF_WAYS = DEF_NUM_OF_WAYS,
    parameter int NUM_OF_SETS = DEF_NUM_OF_SETS
);
    localparam int WAY_W = $clog2(NUM_OF_WAYS);
    localparam int SET_W = $clog2(NUM_OF_SETS);

    logic             flush_i;
    logic             ready_o;
    logic             upd_valid_i;
    logic [SET_W-1:0] upd_set_i;
    logic [WAY_W-1:0] upd_way_i;
    logic             vic_req_i;
    logic [SET_W-1:0] vic_set_i;
`ifdef TREE_PLRU_INVALID_FIRST_EN
    logic [NUM_OF_WAYS-1:0] vic_invalid_i;
`endif
    logic             vic_valid_o;
    logic [WAY_W-1:0] vic_way_o;

    modport master (
        output flush_i, upd_valid_i, upd_set_i, upd_way_i, vic_req_i, vic_set_i,
`ifdef TREE_PLRU_INVALID_FIRST_EN
        output vic_invalid_i,
`endif
        input  ready_o, vic_valid_o, vic_way_o
    );

    modport slave (
        input  flush_i, upd_valid_i, upd_set_i, upd_way_i, vic_req_i, vic_set_i,
`ifdef TREE_PLRU_INVALID_FIRST_EN
        input  vic_invalid_i,
`endif
        output ready_o, vic_valid_o, vic_way_o
    );

endinterface

// File: rtl/tree_plru_table_path.sv
// Combinational tree walk for one set: victim way from the stored bits, and
// the tree after recording an access to way_i (path nodes point away).
module tree_plru_path
    import tree_plru_pkg::*;
#(
    parameter int NUM_OF_WAYS = DEF_NUM_OF_WAYS,
    localparam int WAY_W  = $clog2(NUM_OF_WAYS),
    localparam int TREE_W = NUM_OF_WAYS - 1
) (
    input  logic [TREE_W-1:0] tree_i,
    input  logic [WAY_W-1:0]  way_i,
    output logic [WAY_W-1:0]  victim_o,
    output logic [TREE_W-1:0] tree_o
);

    // Node numbers 1..NUM_OF_WAYS-1 fit in WAY_W bits; bit index is node-1.
    logic [WAY_W-1:0] walk_node;
    logic [WAY_W-1:0] upd_node;
    logic             walk_bit;
    logic             upd_bit;

    // Walk from node 1 following stored bits; bit taken at layer k is way bit L-1-k.
    always_comb begin
        // NOTE: every variable gets a value before any branch or loop, so no latch is inferred.
        victim_o  = '0;
        walk_node = WAY_W'(1);
        walk_bit  = 1'b0;
        for (int k = 0; k < WAY_W; k++) begin
            walk_bit                = tree_i[walk_node - WAY_W'(1)];
            victim_o[WAY_W-1-k]     = walk_bit;
            walk_node               = (walk_node << 1) | WAY_W'(walk_bit);
        end
    end

    // Invert every node on the path to way_i; off-path nodes pass through.
    always_comb begin
        tree_o   = tree_i;
        upd_node = WAY_W'(1);
        upd_bit  = 1'b0;
        for (int k = 0; k < WAY_W; k++) begin
            upd_bit                       = way_i[WAY_W-1-k];
            tree_o[upd_node - WAY_W'(1)]  = ~upd_bit;
            upd_node                      = (upd_node << 1) | WAY_W'(upd_bit);
        end
    end

endmodule

// File: rtl/tree_plru_table.sv
// Tree pseudo-LRU replacement table: one tree per set, initialised by a
// one-set-per-cycle sweep after reset or flush, single-cycle victim lookup
// with same-cycle update forwarding.
// Optional feature macro: TREE_PLRU_INVALID_FIRST_EN (lowest invalid way wins).
module tree_plru_table
    import tree_plru_pkg::*;
#(
    parameter int NUM_OF_WAYS = DEF_NUM_OF_WAYS,
    parameter int NUM_OF_SETS = DEF_NUM_OF_SETS
) (
    input  logic             clk,
    input  logic             rst,
    tree_plru_table_if.slave bus
);

    localparam int WAY_W  = $clog2(NUM_OF_WAYS);
    localparam int SET_W  = $clog2(NUM_OF_SETS);
    localparam int TREE_W = NUM_OF_WAYS - 1;

    state_e           state;
    logic [SET_W-1:0] init_cnt;

    logic [TREE_W-1:0] tree_mem [NUM_OF_SETS];

    logic              ready;
    logic              upd_fire;
    logic [TREE_W-1:0] upd_tree_old;
    logic [TREE_W-1:0] upd_tree_new;
    logic [TREE_W-1:0] vic_tree;
    logic [WAY_W-1:0]  tree_victim;
    logic [WAY_W-1:0]  vic_sel;
    logic [WAY_W-1:0]  unused_upd_victim;
    logic [TREE_W-1:0] unused_vic_tree;

    logic              mem_we;
    logic [SET_W-1:0]  mem_waddr;
    logic [TREE_W-1:0] mem_wdata;

    assign ready       = (state == READY);
    assign bus.ready_o = ready;
    assign upd_fire    = ready && bus.upd_valid_i;

    // Update path: read-modify-write of the accessed set's tree.
    assign upd_tree_old = tree_mem[bus.upd_set_i];

    tree_plru_path #(.NUM_OF_WAYS(NUM_OF_WAYS)) u_upd_path (
        .tree_i   (upd_tree_old),
        .way_i    (bus.upd_way_i),
        .victim_o (unused_upd_victim),
        .tree_o   (upd_tree_new)
    );

    // Victim path sees the post-update tree when both target the same set.
    assign vic_tree = (upd_fire && (bus.upd_set_i == bus.vic_set_i)) ? upd_tree_new
                                                                      : tree_mem[bus.vic_set_i];

    tree_plru_path #(.NUM_OF_WAYS(NUM_OF_WAYS)) u_vic_path (
        .tree_i   (vic_tree),
        .way_i    ('0),
        .victim_o (tree_victim),
        .tree_o   (unused_vic_tree)
    );

`ifdef TREE_PLRU_INVALID_FIRST_EN
    // Any invalid way beats the tree; descending scan leaves the lowest index.
    always_comb begin
        vic_sel = tree_victim;
        for (int i = NUM_OF_WAYS - 1; i >= 0; i--) begin
            if (bus.vic_invalid_i[i]) vic_sel = WAY_W'(i);
        end
    end
`else
    assign vic_sel = tree_victim;
`endif

    // Single write port: sweep clears one set per cycle, otherwise accepted updates.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.upd_set_i;
        mem_wdata = upd_tree_new;
        if (state == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt;
            mem_wdata = '0;
        end else if (upd_fire) begin
            mem_we = 1'b1;
        end
    end

    // Tree storage write.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; the INIT sweep defines its contents before use.
        if (mem_we) tree_mem[mem_waddr] <= mem_wdata;
    end

    // Sweep FSM; flush is honoured only from READY so an active sweep runs to completion.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else if (state == INIT) begin
            init_cnt <= init_cnt + SET_W'(1);
            if (init_cnt == SET_W'(NUM_OF_SETS - 1)) state <= READY;
        end else if (bus.flush_i) begin
            state    <= INIT;
            init_cnt <= '0;
        end
    end

    // Registered victim result; vic_way_o holds when no request is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.vic_valid_o <= 1'b0;
            bus.vic_way_o   <= '0;
        end else begin
            bus.vic_valid_o <= ready && bus.vic_req_i;
            if (ready && bus.vic_req_i) bus.vic_way_o <= vic_sel;
        end
    end

endmodule
